if_fetch_unit: RTL

//  IF-stage PC register + Wishbone instruction-fetch master; the consumer end of the pipeline ctrl handshake.

---
 rtl/if_fetch_unit.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//   IF-stage PC register and Wishbone instruction-fetch master. Issues one
//   read per instruction, requests a pipeline stall while a fetch is
//   outstanding, and follows ctrl's stall/flush/new_pc together with
//   ID-resolved branches. Delivers {pc_o, inst_o, inst_valid_o} to if_id.
//
// Parameters
//   RESET_PC          first fetch address after reset
//
// Optional feature
//   IF_ADEL_CHECK_EN  when defined, a misaligned PC starts no bus cycle and is
//                     delivered as {pc, 0, valid} with fetch_adel_o=1; the PC
//                     then holds until a flush. When undefined, fetch_adel_o
//                     is tied 0.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   stall[5:0]               ctrl stall vector ([0] PC hold, [1] IF hold)
//   flush, new_pc            ctrl redirect
//   branch_flag_i/target_i   ID-resolved taken branch
//   stallreq_from_if         fetch not complete
//   pc_o/inst_o/inst_valid_o delivered instruction (0 on bubble)
//   fetch_adel_o             misaligned-fetch flag
//   wb_*                     Wishbone read master
// -----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        stallreq_from_if,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        fetch_adel_o,
    output logic [31:0] wb_adr_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUSY,
        S_HOLD,
        S_DROP,
        S_ERR
    } state_t;

    state_t      state, state_nx;

    logic [31:0] pc;
    logic [31:0] br_tgt;
    logic        pend_br;
    logic [31:0] adr_q;
    logic [31:0] inst_buf;
    logic [31:0] next_pc;
    logic        misaligned;

    logic        start;
    logic        deliver_bus;
    logic        deliver_buf;
    logic        adel_hit;
    logic        deliver;
    logic [31:0] deliver_data;

    logic        unused_stall;
    assign unused_stall = ^stall[5:2];

    assign next_pc = pend_br ? br_tgt : pc + 32'd4;

`ifdef IF_ADEL_CHECK_EN
    assign misaligned = (pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and per-cycle control strobes
    always_comb begin
        state_nx    = state;
        start       = 1'b0;
        deliver_bus = 1'b0;
        deliver_buf = 1'b0;
        adel_hit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!flush) begin
                    if (misaligned) begin
                        // Fault is reported like a delivered instruction, so it
                        // respects the IF hold just as a normal delivery does.
                        if (!stall[1]) begin
                            adel_hit = 1'b1;
                            state_nx = S_ERR;
                        end
                    end else begin
                        start    = 1'b1;
                        state_nx = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (flush) begin
                    // A same-cycle ack completes the cycle, so no DROP needed.
                    state_nx = wb_ack_i ? S_IDLE : S_DROP;
                end else if (wb_ack_i) begin
                    if (stall[1]) begin
                        state_nx = S_HOLD;
                    end else begin
                        deliver_bus = 1'b1;
                        state_nx    = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                if (flush) begin
                    state_nx = S_IDLE;
                end else if (!stall[1]) begin
                    deliver_buf = 1'b1;
                    state_nx    = S_IDLE;
                end
            end
            S_DROP: begin
                if (wb_ack_i) begin
                    state_nx = S_IDLE;
                end
            end
            S_ERR: begin
                if (flush) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Bus-facing outputs decoded from state
    always_comb begin
        wb_cyc_o         = 1'b0;
        stallreq_from_if = 1'b0;
        case (state)
            S_BUSY: begin
                wb_cyc_o         = 1'b1;
                stallreq_from_if = !wb_ack_i;
            end
            S_DROP: begin
                wb_cyc_o         = 1'b1;
                stallreq_from_if = 1'b1;
            end
            default: begin
                wb_cyc_o         = 1'b0;
                stallreq_from_if = 1'b0;
            end
        endcase
    end

    assign wb_stb_o = wb_cyc_o;
    assign wb_we_o  = 1'b0;
    assign wb_sel_o = 4'b1111;
    assign wb_adr_o = adr_q;

    assign deliver      = deliver_bus | deliver_buf | adel_hit;
    assign deliver_data = deliver_buf ? inst_buf :
                          adel_hit    ? 32'h0000_0000 : wb_dat_i;

    // PC, branch capture, bus address, hold buffer and output register
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc           <= RESET_PC;
            pend_br      <= 1'b0;
            br_tgt       <= '0;
            adr_q        <= '0;
            inst_buf     <= '0;
            pc_o         <= '0;
            inst_o       <= '0;
            inst_valid_o <= 1'b0;
            fetch_adel_o <= 1'b0;
        end else begin
            if (start) begin
                adr_q <= {pc[31:2], 2'b00};
            end
            if (state == S_BUSY && wb_ack_i && stall[1] && !flush) begin
                inst_buf <= wb_dat_i;
            end

            if (flush) begin
                pc <= new_pc;
            end else if (deliver_bus || deliver_buf) begin
                pc <= next_pc;
            end

            // Any flush abandons the path a pending branch belonged to.
            // A branch captured in the same cycle the old one is consumed
            // overrides the clear.
            if (flush) begin
                pend_br <= 1'b0;
            end else begin
                if (deliver_bus || deliver_buf) begin
                    pend_br <= 1'b0;
                end
                if (branch_flag_i && !stall[0]) begin
                    pend_br <= 1'b1;
                    br_tgt  <= branch_target_i;
                end
            end

            if (flush) begin
                pc_o         <= '0;
                inst_o       <= '0;
                inst_valid_o <= 1'b0;
                fetch_adel_o <= 1'b0;
            end else if (deliver) begin
                pc_o         <= pc;
                inst_o       <= deliver_data;
                inst_valid_o <= 1'b1;
                fetch_adel_o <= adel_hit;
            end else if (!stall[1]) begin
                pc_o         <= '0;
                inst_o       <= '0;
                inst_valid_o <= 1'b0;
                fetch_adel_o <= 1'b0;
            end
        end
    end

endmodule
